wd_window_timer: RTL and testbench

//  Upstream timing stage of the watchdog fail detector. Generates the service-window status (SWSTAT),
//  a clean one-cycle service strobe (WDSRVC) from the raw software kick, and the timeout overflow (FWOVR).

---
 rtl/wd_window_timer.sv | 92 +++++++++
 tb/tb_wd_window_timer.sv | 113 +++++++++++
 2 files changed

// File: rtl/wd_window_timer.sv
// wd_window_timer: watchdog service-window generator with kick strobe and sticky timeout overflow.
// Optional `WD_KICK_SYNC_EN adds a 2-flop synchronizer on kick_i before edge detection.
module wd_window_timer #(
  parameter int CLOSED_CYC = 16,
  parameter int OPEN_CYC   = 8,
  parameter int TMO_CYC    = 64,
  parameter int CNT_W      = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en_i,
  input  logic       kick_i,
  output logic       swstat_o,
  output logic       wdsrvc_o,
  output logic       fwovr_o,
  output logic [1:0] phase_o
);
  typedef enum logic [1:0] {IDLE = 2'b00, CLOSED = 2'b01, OPEN = 2'b10, EXPIRED = 2'b11} state_t;
  state_t state_q;
  logic [CNT_W-1:0] pcnt_q, tcnt_q;
  logic kick_s, kick_q, swstat_q, wdsrvc_q, fwovr_q;
  logic kev, valid, tmo, last_c, last_o;
`ifdef WD_KICK_SYNC_EN
  logic [1:0] sync_q;
  always_ff @(posedge clk)
    sync_q <= rst ? 2'b00 : {sync_q[0], kick_i};
  assign kick_s = sync_q[1];
`else
  assign kick_s = kick_i;
`endif
  assign kev    = kick_s & ~kick_q;
  assign valid  = kev & (state_q == OPEN);
  assign tmo    = tcnt_q == CNT_W'(TMO_CYC - 1);
  assign last_c = pcnt_q == CNT_W'(CLOSED_CYC - 1);
  assign last_o = pcnt_q == CNT_W'(OPEN_CYC - 1);
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      pcnt_q   <= '0;
      tcnt_q   <= '0;
      kick_q   <= 1'b0;
      swstat_q <= 1'b0;
      wdsrvc_q <= 1'b0;
      fwovr_q  <= 1'b0;
    end else begin
      kick_q   <= kick_s;
      swstat_q <= 1'b0;
      wdsrvc_q <= 1'b0;
      fwovr_q  <= 1'b0;
      if (!en_i) begin
        state_q <= IDLE;
        pcnt_q  <= '0;
        tcnt_q  <= '0;
      end else begin
        unique case (state_q)
          IDLE: begin
            state_q <= CLOSED;
            pcnt_q  <= '0;
            tcnt_q  <= '0;
          end
          EXPIRED: fwovr_q <= 1'b1;
          default: begin
            if (tmo && !valid) begin
              state_q <= EXPIRED;
              pcnt_q  <= '0;
              fwovr_q <= 1'b1;
            end else begin
              wdsrvc_q <= kev;
              tcnt_q   <= valid ? '0 : tcnt_q + 1'b1;
              if (state_q == CLOSED) begin
                state_q  <= last_c ? OPEN : CLOSED;
                pcnt_q   <= last_c ? '0 : pcnt_q + 1'b1;
                swstat_q <= last_c;
              end else if (last_o && !kev) begin
                state_q <= CLOSED;
                pcnt_q  <= '0;
              end else begin
                // a kick on the last open cycle holds the window open one extra cycle
                swstat_q <= 1'b1;
                pcnt_q   <= last_o ? pcnt_q : pcnt_q + 1'b1;
              end
            end
          end
        endcase
      end
    end
  end
  assign swstat_o = swstat_q;
  assign wdsrvc_o = wdsrvc_q;
  assign fwovr_o  = fwovr_q;
  assign phase_o  = state_q;
endmodule

// File: tb/tb_wd_window_timer.sv
// tb_wd_window_timer: table-driven checks of window phases, kick strobes, guard and timeout.
module tb_wd_window_timer;
`ifdef WD_KICK_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif
  logic clk = 1'b0, rst = 1'b1;
  logic en0 = 1'b0, kick0 = 1'b0, en1 = 1'b0, kick1 = 1'b0;
  logic sw0, srv0, ov0, sw1, srv1, ov1;
  logic [1:0] ph0, ph1;
  int n_cmp = 0, n_bad = 0;
  typedef struct {int scen; int cyc; logic [4:0] exp;} vec_t;
  vec_t vt[$];
  int kick_at[6];
  always #5 clk = ~clk;
  wd_window_timer u0 (.clk(clk), .rst(rst), .en_i(en0), .kick_i(kick0),
    .swstat_o(sw0), .wdsrvc_o(srv0), .fwovr_o(ov0), .phase_o(ph0));
  wd_window_timer #(.CLOSED_CYC(4), .OPEN_CYC(4), .TMO_CYC(16), .CNT_W(8)) u1 (.clk(clk), .rst(rst),
    .en_i(en1), .kick_i(kick1), .swstat_o(sw1), .wdsrvc_o(srv1), .fwovr_o(ov1), .phase_o(ph1));
  function automatic logic [4:0] e(logic sw, logic srv, logic ov, logic [1:0] ph);
    return {sw, srv, ov, ph};
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(string name, int c, logic [4:0] act, logic [4:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc %0d: got sw/srv/ov/ph=%b required %b", name, c, act, exp);
    end
  endtask
  task automatic do_reset();
    rst = 1'b1; en0 = 1'b0; kick0 = 1'b0; en1 = 1'b0; kick1 = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask
  initial begin
    kick_at = '{-1, -1, -1, 18, 5, 24 - LAT};
    vt.push_back('{2, 0,  e(0, 0, 0, 2'b01)});
    vt.push_back('{2, 15, e(0, 0, 0, 2'b01)});
    vt.push_back('{2, 16, e(1, 0, 0, 2'b10)});
    vt.push_back('{2, 23, e(1, 0, 0, 2'b10)});
    vt.push_back('{2, 24, e(0, 0, 0, 2'b01)});
    vt.push_back('{2, 63, e(0, 0, 0, 2'b01)});
    vt.push_back('{2, 64, e(0, 0, 1, 2'b11)});
    vt.push_back('{2, 70, e(0, 0, 1, 2'b11)});
    vt.push_back('{3, 18 + LAT, e(1, 1, 0, 2'b10)});
    vt.push_back('{3, 19 + LAT, e(1, 0, 0, 2'b10)});
    vt.push_back('{3, 64, e(1, 0, 0, 2'b10)});
    vt.push_back('{3, 70, e(1, 0, 0, 2'b10)});
    vt.push_back('{4, 5 + LAT, e(0, 1, 0, 2'b01)});
    vt.push_back('{4, 6 + LAT, e(0, 0, 0, 2'b01)});
    vt.push_back('{4, 63, e(0, 0, 0, 2'b01)});
    vt.push_back('{4, 64, e(0, 0, 1, 2'b11)});
    vt.push_back('{5, 23, e(1, 0, 0, 2'b10)});
    vt.push_back('{5, 24, e(1, 1, 0, 2'b10)});
    vt.push_back('{5, 25, e(0, 0, 0, 2'b01)});
    vt.push_back('{5, 40, e(0, 0, 0, 2'b01)});
    vt.push_back('{5, 41, e(1, 0, 0, 2'b10)});
    vt.push_back('{5, 64, e(0, 0, 0, 2'b01)});
    for (int s = 2; s <= 5; s++) begin
      do_reset();
      chk("reset", -1, {sw0, srv0, ov0, ph0}, 5'b0);
      en0 = 1'b1;
      for (int c = 0; c <= 70; c++) begin
        tick();
        if (c == kick_at[s]) kick0 = 1'b1;
        foreach (vt[i])
          if (vt[i].scen == s && vt[i].cyc == c)
            chk($sformatf("scen%0d", s), c, {sw0, srv0, ov0, ph0}, vt[i].exp);
      end
      en0 = 1'b0;
      tick();
      chk($sformatf("scen%0d_en_off", s), 71, {sw0, srv0, ov0, ph0}, 5'b0);
    end
    do_reset();
    en0 = 1'b1;
    for (int c = 0; c <= 18; c++) tick();
    chk("mid_open", 18, {sw0, srv0, ov0, ph0}, e(1, 0, 0, 2'b10));
    kick0 = 1'b1;
    rst = 1'b1;
    tick();
    chk("rst_abort", 19, {sw0, srv0, ov0, ph0}, 5'b0);
    rst = 1'b0;
    tick();
    chk("rst_no_strobe", 20, {sw0, srv0, ov0, ph0}, e(0, 0, 0, 2'b01));
    tick();
    chk("rst_no_strobe2", 21, {sw0, srv0, ov0, ph0}, e(0, 0, 0, 2'b01));
    do_reset();
    en1 = 1'b1;
    for (int c = 0; c <= 16; c++) begin
      tick();
      if (c == 15) chk("u1_pre_tmo", c, {sw1, srv1, ov1, ph1}, e(1, 0, 0, 2'b10));
      if (c == 16) chk("u1_tmo", c, {sw1, srv1, ov1, ph1}, e(0, 0, 1, 2'b11));
    end
    do_reset();
    en1 = 1'b1;
    for (int c = 0; c <= 32; c++) begin
      tick();
      if (c == 16 - LAT) kick1 = 1'b1;
      if (c == 16) chk("u1_kick_wins", c, {sw1, srv1, ov1, ph1}, e(1, 1, 0, 2'b10));
      if (c == 17) chk("u1_guard_close", c, {sw1, srv1, ov1, ph1}, e(0, 0, 0, 2'b01));
      if (c == 31) chk("u1_cleared", c, {sw1, srv1, ov1, ph1}, e(1, 0, 0, 2'b10));
      if (c == 32) chk("u1_tmo2", c, {sw1, srv1, ov1, ph1}, e(0, 0, 1, 2'b11));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
